// File: rtl/e203_rst_sequencer_if.sv
// Reset sequencer handshake bundle: lock/request inputs,
// staged reset outputs and status.
interface e203_rst_sequencer_if #(
  parameter int N_OUT = 4
);
  logic             pll_lock;
  logic             sw_rst_req;
  logic             wdog_rst;
  logic             cause_clr;
  logic [N_OUT-1:0] rst_n_out;
  logic             all_released;
  logic [2:0]       seq_state;
  logic [3:0]       rst_cause;

  modport master (
    output pll_lock,
    output sw_rst_req,
    output wdog_rst,
    output cause_clr,
    input  rst_n_out,
    input  all_released,
    input  seq_state,
    input  rst_cause
  );

  modport slave (
    input  pll_lock,
    input  sw_rst_req,
    input  wdog_rst,
    input  cause_clr,
    output rst_n_out,
    output all_released,
    output seq_state,
    output rst_cause
  );
endinterface

// File: rtl/e203_rst_sequencer.sv
// SoC reset sequencer: filters PLL lock, then releases
// N_OUT reset domains in order; tracks a sticky reset cause.
module e203_rst_sequencer #(
  parameter int N_OUT       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILT   = 4,
  parameter int INIT_DLY    = 1024,
  parameter int STAGE_DLY   = 16,
  parameter int HOLD_CYC    = 8
) (
  input  logic clk,
  input  logic rst_n,
  e203_rst_sequencer_if.slave io
);

  localparam int M0 = (LOCK_FILT > INIT_DLY) ? LOCK_FILT : INIT_DLY;
  localparam int M1 = (STAGE_DLY > HOLD_CYC) ? STAGE_DLY : HOLD_CYC;
  localparam int MX = (M0 > M1) ? M0 : M1;
  localparam int CW = $clog2(MX) + 1;
  localparam int SW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_WAIT  = 3'd1,
    S_DELAY = 3'd2,
    S_REL   = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [SW-1:0]          r_stage;
  logic [N_OUT-1:0]       r_rst_n;
  logic                   r_all;
  logic [3:0]             r_cause;
  logic [SYNC_STAGES-1:0] r_sync;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [SW-1:0]    w_stage_nxt;
  logic [N_OUT-1:0] w_rst_n_nxt;
  logic             w_all_nxt;
  logic [3:0]       w_cause_nxt;
  logic             w_lock_s;
  logic             w_loss;
  logic             w_req;

  assign w_lock_s = r_sync[SYNC_STAGES-1];
  assign w_req    = io.wdog_rst | io.sw_rst_req;
  assign w_loss   = !w_lock_s &&
                    (r_state == S_DELAY ||
                     r_state == S_REL   ||
                     r_state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], io.pll_lock};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
      r_stage <= '0;
      r_rst_n <= '0;
      r_all   <= 1'b0;
      r_cause <= 4'b0001;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_all   <= w_all_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_rst_n_nxt = r_rst_n;
    w_all_nxt   = r_all;
    w_cause_nxt = io.cause_clr ? 4'b0000 : r_cause;
    // a firing event beats a same-cycle clear
    w_cause_nxt = w_cause_nxt |
                  {io.wdog_rst, io.sw_rst_req, w_loss, 1'b0};

    if (w_req && r_state != S_HOLD) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
      w_rst_n_nxt = '0;
      w_all_nxt   = 1'b0;
    end else if (w_loss) begin
      w_state_nxt = S_WAIT;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
      w_rst_n_nxt = '0;
      w_all_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_HOLD: begin
          if (r_cnt == CW'(HOLD_CYC - 1)) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          // lock accepted one edge after the filter count fills
          if (!w_lock_s) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CW'(LOCK_FILT)) begin
            w_state_nxt = S_DELAY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DELAY: begin
          if (r_cnt == CW'(INIT_DLY - 1)) begin
            w_state_nxt = S_REL;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
            w_rst_n_nxt = N_OUT'(1);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_REL: begin
          if (r_cnt == CW'(STAGE_DLY - 1)) begin
            w_cnt_nxt = '0;
            if (r_stage == SW'(N_OUT - 1)) begin
              w_state_nxt = S_RUN;
              w_all_nxt   = 1'b1;
            end else begin
              w_stage_nxt    = r_stage + 1'b1;
              w_rst_n_nxt[0] = 1'b1;
              for (int i = 1; i < N_OUT; i++) begin
                w_rst_n_nxt[i] = r_rst_n[i-1];
              end
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
          w_rst_n_nxt = '0;
          w_all_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign io.rst_n_out    = r_rst_n;
  assign io.all_released = r_all;
  assign io.seq_state    = r_state;
  assign io.rst_cause    = r_cause;

endmodule

// File: tb/tb_e203_rst_sequencer.sv
// Directed bench for e203_rst_sequencer: startup timing table,
// lock glitch, lock loss, sw/wdog hold, async reset, cause clear.
module tb_e203_rst_sequencer;

  logic clk;
  logic rst_n;
  int   ecnt;
  int   nchk;
  int   nerr;

  e203_rst_sequencer_if #(.N_OUT(3)) bus ();

  e203_rst_sequencer #(
    .N_OUT(3),
    .SYNC_STAGES(2),
    .LOCK_FILT(4),
    .INIT_DLY(8),
    .STAGE_DLY(4),
    .HOLD_CYC(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus.slave)
  );

  typedef struct {
    int         e;
    logic [2:0] out;
    logic       all;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (edge %0d)",
               nm, act, exp, ecnt);
    end
  endtask

  task automatic chk_out(input string nm, input int o,
                         input int a, input int s);
    chk({nm, ".out"}, int'(bus.rst_n_out), o);
    chk({nm, ".all"}, int'(bus.all_released), a);
    chk({nm, ".st"}, int'(bus.seq_state), s);
  endtask

  task automatic play(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      while (ecnt < s + tbl[i].e) tick();
      chk_out($sformatf("tbl%0d", i), int'(tbl[i].out),
              int'(tbl[i].all), int'(tbl[i].st));
    end
  endtask

  int s;
  int h;
  int x;

  initial begin
    tbl[0]  = '{1,  3'b000, 1'b0, 3'd1};
    tbl[1]  = '{5,  3'b000, 1'b0, 3'd1};
    tbl[2]  = '{6,  3'b000, 1'b0, 3'd2};
    tbl[3]  = '{13, 3'b000, 1'b0, 3'd2};
    tbl[4]  = '{14, 3'b001, 1'b0, 3'd3};
    tbl[5]  = '{17, 3'b001, 1'b0, 3'd3};
    tbl[6]  = '{18, 3'b011, 1'b0, 3'd3};
    tbl[7]  = '{21, 3'b011, 1'b0, 3'd3};
    tbl[8]  = '{22, 3'b111, 1'b0, 3'd3};
    tbl[9]  = '{25, 3'b111, 1'b0, 3'd3};
    tbl[10] = '{26, 3'b111, 1'b1, 3'd4};

    ecnt = 0;
    nchk = 0;
    nerr = 0;
    rst_n = 1'b0;
    bus.pll_lock   = 1'b0;
    bus.sw_rst_req = 1'b0;
    bus.wdog_rst   = 1'b0;
    bus.cause_clr  = 1'b0;

    #12;
    chk_out("reset", 0, 0, 1);
    chk("reset.cause", int'(bus.rst_cause), 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // startup sequence
    bus.pll_lock = 1'b1;
    s = ecnt + 1;
    play(s, 11);
    chk("s1.cause", int'(bus.rst_cause), 4'b0001);

    // lock loss in RUN
    bus.pll_lock = 1'b0;
    tick();
    tick();
    chk_out("loss.pre", 3'b111, 1, 4);
    tick();
    chk_out("loss", 0, 0, 1);
    chk("loss.cause", int'(bus.rst_cause), 4'b0011);
    tick();
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    chk("clr.cause", int'(bus.rst_cause), 4'b0000);
    tick();

    // relock, then sw+wdog together in RELEASE
    bus.pll_lock = 1'b1;
    s = ecnt + 1;
    play(s, 7);
    bus.sw_rst_req = 1'b1;
    bus.wdog_rst   = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    bus.wdog_rst   = 1'b0;
    h = ecnt;
    chk_out("hold", 0, 0, 0);
    chk("hold.cause", int'(bus.rst_cause), 4'b1100);
    while (ecnt < h + 2) tick();
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    chk("hold.clr", int'(bus.rst_cause), 4'b0000);
    tick();
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    chk("hold.sw", int'(bus.rst_cause), 4'b0100);
    while (ecnt < h + 7) tick();
    chk_out("hold.end", 0, 0, 0);
    tick();
    chk_out("hold.exit", 0, 0, 1);
    while (ecnt < h + 20) tick();
    chk_out("rehold.dly", 0, 0, 2);
    tick();
    chk_out("rehold.rel", 3'b001, 0, 3);

    // cause_clr in the same cycle as lock loss
    x = ecnt;
    bus.pll_lock = 1'b0;
    tick();
    tick();
    chk_out("clrloss.pre", 3'b001, 0, 3);
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    chk("clrloss.cause", int'(bus.rst_cause), 4'b0010);
    chk_out("clrloss", 0, 0, 1);
    tick();
    tick();
    tick();

    // lock glitch: high 3, low 1, then high
    bus.pll_lock = 1'b1;
    s = ecnt + 1;
    tick();
    tick();
    tick();
    bus.pll_lock = 1'b0;
    tick();
    bus.pll_lock = 1'b1;
    play(s + 4, 11);

    // watchdog from RUN, then async reset mid-RELEASE
    bus.wdog_rst = 1'b1;
    tick();
    bus.wdog_rst = 1'b0;
    h = ecnt;
    chk_out("wdog", 0, 0, 0);
    chk("wdog.cause", int'(bus.rst_cause), 4'b1010);
    while (ecnt < h + 26) tick();
    chk_out("wdog.rel", 3'b011, 0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 0, 0, 1);
    chk("arst.cause", int'(bus.rst_cause), 4'b0001);
    #10;
    rst_n = 1'b1;
    tick();
    chk_out("arst.after", 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
